// File: rtl/aqfp_excite_seq.sv
// aqfp_excite_seq: DC-bias warm-up plus 4-phase AC excitation sequencer
// for one AQFP gate pipeline under test, with output capture.
module aqfp_excite_seq #(
   parameter int DATA_W   = 8,
   parameter int DEPTH_W  = 6,
   parameter int WARM_CYC = 4,
   parameter int PH_DIV   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [DEPTH_W-1:0] depth,
   input  logic [DATA_W-1:0]  vec_in,
   input  logic [DATA_W-1:0]  dout_smp,
   output logic               busy,
   output logic               done,
   output logic               dc_en,
   output logic [3:0]         xclk,
   output logic [DATA_W-1:0]  din_drv,
   output logic [DATA_W-1:0]  result
);

   typedef enum logic [1:0] {
      IDLE,
      WARM,
      RUN,
      DONE
   } state_t;

   localparam logic [7:0] WLAST = 8'(WARM_CYC - 1);
   localparam logic [7:0] DLAST = 8'(PH_DIV - 1);
   localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);

   state_t             state;
   logic [7:0]         wcnt;
   logic [7:0]         dcnt;
   logic [DEPTH_W-1:0] pcnt;
   logic [DEPTH_W-1:0] depth_q;
   logic [1:0]         pidx;
   logic [1:0]         nidx;
   logic               ph_end;
   logic               last_ph;

   // next phase index and end-of-phase / last-phase decode
   always_comb begin
      nidx    = pidx + 2'd1;
      ph_end  = (dcnt == DLAST);
      last_ph = (pcnt == depth_q - D_ONE);
   end

   // sequencer FSM; all drives are registered so they change only on edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         wcnt    <= '0;
         dcnt    <= '0;
         pcnt    <= '0;
         pidx    <= '0;
         depth_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dc_en   <= 1'b0;
         xclk    <= '0;
         din_drv <= '0;
         result  <= '0;
      end else if (abort && (state == WARM || state == RUN)) begin
         state   <= IDLE;
         busy    <= 1'b0;
         dc_en   <= 1'b0;
         xclk    <= '0;
         din_drv <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= WARM;
                  busy    <= 1'b1;
                  dc_en   <= 1'b1;
                  din_drv <= vec_in;
                  depth_q <= (depth == '0) ? D_ONE : depth;
                  wcnt    <= '0;
               end
            end
            WARM: begin
               if (wcnt == WLAST) begin
                  state <= RUN;
                  xclk  <= 4'b0001;
                  pidx  <= '0;
                  pcnt  <= '0;
                  dcnt  <= '0;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            RUN: begin
               if (!ph_end) begin
                  dcnt <= dcnt + 8'd1;
               end else if (last_ph) begin
                  state  <= DONE;
                  result <= dout_smp;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  dc_en  <= 1'b0;
                  xclk   <= '0;
               end else begin
                  dcnt <= '0;
                  pidx <= nidx;
                  pcnt <= pcnt + D_ONE;
                  xclk <= 4'b0001 << nidx;
               end
            end
            DONE: begin
               state   <= IDLE;
               done    <= 1'b0;
               din_drv <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aqfp_excite_seq.sv
// tb_aqfp_excite_seq: directed scenario bench for aqfp_excite_seq.
// u0 uses PH_DIV=2, u1 uses PH_DIV=1; both share the stimulus.
module tb_aqfp_excite_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [5:0] depth;
   logic [7:0] vec_in;
   logic [7:0] dout_smp;

   logic       busy0, done0, dc_en0;
   logic [3:0] xclk0;
   logic [7:0] din0, res0;
   logic       busy1, done1, dc_en1;
   logic [3:0] xclk1;
   logic [7:0] din1, res1;

   logic [14:0] st0, st1;
   int checks = 0;
   int failures = 0;

   assign st0 = {busy0, done0, dc_en0, xclk0, din0};
   assign st1 = {busy1, done1, dc_en1, xclk1, din1};

   always #5 clk = ~clk;

   aqfp_excite_seq #(.DATA_W(8), .DEPTH_W(6), .WARM_CYC(4), .PH_DIV(2)) u0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .depth(depth),
      .vec_in(vec_in), .dout_smp(dout_smp), .busy(busy0), .done(done0),
      .dc_en(dc_en0), .xclk(xclk0), .din_drv(din0), .result(res0)
   );

   aqfp_excite_seq #(.DATA_W(8), .DEPTH_W(6), .WARM_CYC(4), .PH_DIV(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .depth(depth),
      .vec_in(vec_in), .dout_smp(dout_smp), .busy(busy1), .done(done1),
      .dc_en(dc_en1), .xclk(xclk1), .din_drv(din1), .result(res1)
   );

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      depth = '0; vec_in = '0; dout_smp = '0;
      tick(); tick();
      checks++;
      if (st0 !== 15'h0) begin
         failures++;
         $display("FAIL reset_drives got=%h exp=%h", st0, 15'h0);
      end
      checks++;
      if (res0 !== 8'h00) begin
         failures++;
         $display("FAIL reset_result got=%h exp=00", res0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [3:0] ex [6] = '{4'b0001, 4'b0001, 4'b0010,
                             4'b0010, 4'b0100, 4'b0100};
      dout_smp = 8'h11;
      vec_in = 8'hA5; depth = 6'd3; start = 1'b1;
      tick();
      start = 1'b0; vec_in = 8'h00;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (st0 !== {3'b101, 4'b0000, 8'hA5}) begin
            failures++;
            $display("FAIL basic_warm%0d got=%h exp=%h", k, st0,
                     {3'b101, 4'b0000, 8'hA5});
         end
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         dout_smp = (k == 5) ? 8'h3C : 8'h11;
         checks++;
         if (st0 !== {3'b101, ex[k], 8'hA5}) begin
            failures++;
            $display("FAIL basic_run%0d got=%h exp=%h", k, st0,
                     {3'b101, ex[k], 8'hA5});
         end
         tick();
      end
      dout_smp = 8'h77;
      checks++;
      if (st0 !== {3'b010, 4'b0000, 8'hA5}) begin
         failures++;
         $display("FAIL basic_done got=%h exp=%h", st0,
                  {3'b010, 4'b0000, 8'hA5});
      end
      checks++;
      if (res0 !== 8'h3C) begin
         failures++;
         $display("FAIL basic_result got=%h exp=3c", res0);
      end
      tick();
      checks++;
      if (st0 !== 15'h0 || res0 !== 8'h3C) begin
         failures++;
         $display("FAIL basic_idle got=%h/%h exp=0000/3c", st0, res0);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] ex [6] = '{4'b0001, 4'b0010, 4'b0100,
                             4'b1000, 4'b0001, 4'b0010};
      vec_in = 8'h5A; depth = 6'd6; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      for (int k = 0; k < 6; k++) begin
         dout_smp = (k == 5) ? 8'hC3 : 8'h22;
         checks++;
         if (st1 !== {3'b101, ex[k], 8'h5A}) begin
            failures++;
            $display("FAIL wrap_run%0d got=%h exp=%h", k, st1,
                     {3'b101, ex[k], 8'h5A});
         end
         tick();
      end
      dout_smp = 8'h00;
      checks++;
      if (st1 !== {3'b010, 4'b0000, 8'h5A} || res1 !== 8'hC3) begin
         failures++;
         $display("FAIL wrap_done got=%h/%h exp=%h/c3", st1, res1,
                  {3'b010, 4'b0000, 8'h5A});
      end
      for (int k = 0; k < 9; k++) tick();
   endtask

   task automatic test_depth_zero();
      vec_in = 8'h0F; depth = 6'd0; start = 1'b1; dout_smp = 8'h00;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      for (int k = 0; k < 2; k++) begin
         dout_smp = (k == 1) ? 8'h99 : 8'h00;
         checks++;
         if (st0 !== {3'b101, 4'b0001, 8'h0F}) begin
            failures++;
            $display("FAIL dz_run%0d got=%h exp=%h", k, st0,
                     {3'b101, 4'b0001, 8'h0F});
         end
         tick();
      end
      dout_smp = 8'h00;
      checks++;
      if (st0 !== {3'b010, 4'b0000, 8'h0F} || res0 !== 8'h99) begin
         failures++;
         $display("FAIL dz_done got=%h/%h exp=%h/99", st0, res0,
                  {3'b010, 4'b0000, 8'h0F});
      end
      tick();
   endtask

   task automatic test_abort();
      vec_in = 8'h6E; depth = 6'd5; start = 1'b1; dout_smp = 8'hEE;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      abort = 1'b1;
      checks++;
      if (st0 !== {3'b101, 4'b0001, 8'h6E}) begin
         failures++;
         $display("FAIL abort_pre got=%h exp=%h", st0,
                  {3'b101, 4'b0001, 8'h6E});
      end
      tick();
      abort = 1'b0;
      for (int k = 0; k < 14; k++) begin
         checks++;
         if (st0 !== 15'h0 || res0 !== 8'h99) begin
            failures++;
            $display("FAIL abort_idle%0d got=%h/%h exp=0000/99", k,
                     st0, res0);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      vec_in = 8'hA5; depth = 6'd3; start = 1'b1; dout_smp = 8'h00;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      tick();
      start = 1'b1; vec_in = 8'hFF; depth = 6'd1;
      tick();
      start = 1'b0; vec_in = 8'h00;
      for (int k = 0; k < 4; k++) begin
         dout_smp = (k == 3) ? 8'h5C : 8'h00;
         checks++;
         if (busy0 !== 1'b1 || din0 !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_run%0d got=%h exp=busy,a5", k, st0);
         end
         tick();
      end
      start = 1'b1; vec_in = 8'h3C; depth = 6'd1;
      checks++;
      if (st0 !== {3'b010, 4'b0000, 8'hA5} || res0 !== 8'h5C) begin
         failures++;
         $display("FAIL b2b_done got=%h/%h exp=%h/5c", st0, res0,
                  {3'b010, 4'b0000, 8'hA5});
      end
      tick();
      checks++;
      if (st0 !== 15'h0) begin
         failures++;
         $display("FAIL b2b_idle got=%h exp=0000", st0);
      end
      tick();
      start = 1'b0;
      checks++;
      if (st0 !== {3'b101, 4'b0000, 8'h3C}) begin
         failures++;
         $display("FAIL b2b_rearm got=%h exp=%h", st0,
                  {3'b101, 4'b0000, 8'h3C});
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int k = 0; k < 8; k++) tick();
   endtask

   task automatic test_async_reset();
      vec_in = 8'h44; depth = 6'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (st0 !== 15'h0 || res0 !== 8'h00) begin
         failures++;
         $display("FAIL arst_now got=%h/%h exp=0000/00", st0, res0);
      end
      tick();
      #3 rst = 1'b0;
      tick();
      vec_in = 8'h81; depth = 6'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      for (int k = 0; k < 4; k++) begin
         dout_smp = (k == 3) ? 8'hB7 : 8'h00;
         checks++;
         if (st0 !== {3'b101, ((k < 2) ? 4'b0001 : 4'b0010), 8'h81}) begin
            failures++;
            $display("FAIL arst_run%0d got=%h", k, st0);
         end
         tick();
      end
      checks++;
      if (st0 !== {3'b010, 4'b0000, 8'h81} || res0 !== 8'hB7) begin
         failures++;
         $display("FAIL arst_done got=%h/%h exp=%h/b7", st0, res0,
                  {3'b010, 4'b0000, 8'h81});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_depth_zero();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
